// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for the memory port arbiter: FSM state encodings,
// requester indices and default RAM geometry.
package mem_port_arbiter_pkg;

  localparam int unsigned ADDR_W_DEF = 10;
  localparam int unsigned DATA_W_DEF = 16;

  // Read requester indices (bit positions in rd_req / rd_ack).
  localparam int unsigned REQ_FETCH = 0;
  localparam int unsigned REQ_DATA  = 1;

  typedef enum logic [1:0] {
    RD_IDLE  = 2'd0,
    RD_ISSUE = 2'd1,
    RD_WAIT  = 2'd2,
    RD_ACK   = 2'd3
  } rd_state_e;

  typedef enum logic {
    WR_IDLE  = 1'b0,
    WR_ISSUE = 1'b1
  } wr_state_e;

endpackage

// File: rtl/mem_port_arbiter_rr_arb2.sv
// Two-input round-robin selector.
// Ports: clk, rst (sync, active-high), req[1:0] requests, grant (selection
// was taken this cycle), sel_c (combinational index of the selected requester).
// last_grant only moves when grant is asserted, so a deferred read keeps
// its place in the rotation.
module rr_arb2
  import mem_port_arbiter_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       grant,
  output logic       sel_c
);

  logic last_grant_q;
  logic last_grant_d;

  // Lone requester wins; on a tie the one not granted last wins.
  always_comb begin
    case (req)
      2'b01:   sel_c = 1'(REQ_FETCH);
      2'b10:   sel_c = 1'(REQ_DATA);
      default: sel_c = ~last_grant_q;
    endcase
    last_grant_d = last_grant_q;
    if (grant) begin
      last_grant_d = sel_c;
    end
  end

  // Reset points at the data requester so fetch wins the first tie.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant_q <= 1'(REQ_DATA);
    end else begin
      last_grant_q <= last_grant_d;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates two read requesters (fetch, data load) onto RAM port B and one
// store requester onto RAM port A of a dual-port RAM with registered output.
// Ports: clka, rst (sync, active-high); rd_req/rd_addr0/rd_addr1 in,
// rd_ack/rd_data out; wr_req/wr_addr/wr_data in, wr_ack out;
// port A ena/wea/addra/dia out; port B enb/addrb out, dob in.
// Read and write FSMs run concurrently; a read to the address being written
// is held off until the write has landed.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned DATA_W = DATA_W_DEF
) (
  input  logic              clka,
  input  logic              rst,
  input  logic [1:0]        rd_req,
  input  logic [ADDR_W-1:0] rd_addr0,
  input  logic [ADDR_W-1:0] rd_addr1,
  output logic [1:0]        rd_ack,
  output logic [DATA_W-1:0] rd_data,
  input  logic              wr_req,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_ack,
  output logic              ena,
  output logic              wea,
  output logic [ADDR_W-1:0] addra,
  output logic [DATA_W-1:0] dia,
  output logic              enb,
  output logic [ADDR_W-1:0] addrb,
  input  logic [DATA_W-1:0] dob
);

  rd_state_e rd_state_q, rd_state_d;
  wr_state_e wr_state_q, wr_state_d;

  logic              rd_gnt_q, rd_gnt_d;
  logic [ADDR_W-1:0] addrb_q, addrb_d;
  logic              enb_q, enb_d;
  logic [1:0]        rd_ack_q, rd_ack_d;
  logic [DATA_W-1:0] rd_data_q, rd_data_d;
  logic [ADDR_W-1:0] addra_q, addra_d;
  logic [DATA_W-1:0] dia_q, dia_d;
  logic              ena_q, ena_d;
  logic              wea_q, wea_d;
  logic              wr_ack_q, wr_ack_d;

  logic              rd_sel_c;
  logic [ADDR_W-1:0] sel_addr;
  logic              wr_accept;
  logic              hazard;
  logic              rd_grant;

  rr_arb2 u_rr_arb2 (
    .clk   (clka),
    .rst   (rst),
    .req   (rd_req),
    .grant (rd_grant),
    .sel_c (rd_sel_c)
  );

  // Read-after-write hazard: selected read address matches a write being
  // accepted now or one still on port A.
  always_comb begin
    wr_accept = (wr_state_q == WR_IDLE) && wr_req;
    sel_addr  = rd_sel_c ? rd_addr1 : rd_addr0;
    hazard    = (wr_accept && (sel_addr == wr_addr)) ||
                ((wr_state_q == WR_ISSUE) && (sel_addr == addra_q));
    rd_grant  = (rd_state_q == RD_IDLE) && (|rd_req) && !hazard;
  end

  // Read FSM next state.
  always_comb begin
    rd_state_d = rd_state_q;
    case (rd_state_q)
      RD_IDLE:  if (rd_grant) rd_state_d = RD_ISSUE;
      RD_ISSUE: rd_state_d = RD_WAIT;
      RD_WAIT:  rd_state_d = RD_ACK;
      RD_ACK:   rd_state_d = RD_IDLE;
      default:  rd_state_d = RD_IDLE;
    endcase
  end

  // Read FSM outputs; enb and rd_ack are single-cycle pulses by default.
  always_comb begin
    rd_gnt_d  = rd_gnt_q;
    addrb_d   = addrb_q;
    enb_d     = 1'b0;
    rd_ack_d  = 2'b00;
    rd_data_d = rd_data_q;
    case (rd_state_q)
      RD_IDLE: begin
        if (rd_grant) begin
          rd_gnt_d = rd_sel_c;
          addrb_d  = sel_addr;
          enb_d    = 1'b1;
        end
      end
      RD_WAIT: begin
        rd_data_d = dob;
        rd_ack_d  = rd_gnt_q ? 2'b10 : 2'b01;
      end
      default: ;
    endcase
  end

  // Write FSM next state.
  always_comb begin
    wr_state_d = wr_state_q;
    if (wr_state_q == WR_IDLE) begin
      if (wr_req) wr_state_d = WR_ISSUE;
    end else begin
      wr_state_d = WR_IDLE;
    end
  end

  // Write FSM outputs.
  always_comb begin
    addra_d  = addra_q;
    dia_d    = dia_q;
    ena_d    = 1'b0;
    wea_d    = 1'b0;
    wr_ack_d = 1'b0;
    if (wr_state_q == WR_IDLE) begin
      if (wr_req) begin
        addra_d = wr_addr;
        dia_d   = wr_data;
        ena_d   = 1'b1;
        wea_d   = 1'b1;
      end
    end else begin
      wr_ack_d = 1'b1;
    end
  end

  // State and output registers.
  always_ff @(posedge clka) begin
    if (rst) begin
      rd_state_q <= RD_IDLE;
      wr_state_q <= WR_IDLE;
      rd_gnt_q   <= 1'b0;
      addrb_q    <= '0;
      enb_q      <= 1'b0;
      rd_ack_q   <= 2'b00;
      rd_data_q  <= '0;
      addra_q    <= '0;
      dia_q      <= '0;
      ena_q      <= 1'b0;
      wea_q      <= 1'b0;
      wr_ack_q   <= 1'b0;
    end else begin
      rd_state_q <= rd_state_d;
      wr_state_q <= wr_state_d;
      rd_gnt_q   <= rd_gnt_d;
      addrb_q    <= addrb_d;
      enb_q      <= enb_d;
      rd_ack_q   <= rd_ack_d;
      rd_data_q  <= rd_data_d;
      addra_q    <= addra_d;
      dia_q      <= dia_d;
      ena_q      <= ena_d;
      wea_q      <= wea_d;
      wr_ack_q   <= wr_ack_d;
    end
  end

  assign rd_ack  = rd_ack_q;
  assign rd_data = rd_data_q;
  assign wr_ack  = wr_ack_q;
  assign ena     = ena_q;
  assign wea     = wea_q;
  assign addra   = addra_q;
  assign dia     = dia_q;
  assign enb     = enb_q;
  assign addrb   = addrb_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a behavioural dual-port RAM.
module tb_mem_port_arbiter;

  logic        clka = 1'b0;
  logic        rst;
  logic [1:0]  rd_req;
  logic [9:0]  rd_addr0, rd_addr1;
  logic [1:0]  rd_ack;
  logic [15:0] rd_data;
  logic        wr_req;
  logic [9:0]  wr_addr;
  logic [15:0] wr_data;
  logic        wr_ack;
  logic        ena, wea, enb;
  logic [9:0]  addra, addrb;
  logic [15:0] dia;
  logic [15:0] dob;

  int checks = 0;
  int failures = 0;

  // RAM model: port A write, port B registered read, plus a preload port.
  logic [15:0] mem [0:1023];
  logic        pre_we = 1'b0;
  logic [9:0]  pre_addr = '0;
  logic [15:0] pre_data = '0;

  always #5 clka = ~clka;

  always @(posedge clka) begin
    if (pre_we) mem[pre_addr] <= pre_data;
    else if (ena && wea) mem[addra] <= dia;
    if (enb) dob <= mem[addrb];
  end

  mem_port_arbiter #(.ADDR_W(10), .DATA_W(16)) dut (
    .clka     (clka),
    .rst      (rst),
    .rd_req   (rd_req),
    .rd_addr0 (rd_addr0),
    .rd_addr1 (rd_addr1),
    .rd_ack   (rd_ack),
    .rd_data  (rd_data),
    .wr_req   (wr_req),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .wr_ack   (wr_ack),
    .ena      (ena),
    .wea      (wea),
    .addra    (addra),
    .dia      (dia),
    .enb      (enb),
    .addrb    (addrb),
    .dob      (dob)
  );

  task automatic step();
    @(posedge clka);
    #1;
  endtask

  task automatic preload(input logic [9:0] a, input logic [15:0] d);
    pre_addr = a;
    pre_data = d;
    pre_we   = 1'b1;
    step();
    pre_we   = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    rd_req = 2'b00; rd_addr0 = '0; rd_addr1 = '0;
    wr_req = 1'b0;  wr_addr = '0;  wr_data = '0;
    step();
    preload(10'h005, 16'h0C01);
    preload(10'h010, 16'h1010);
    preload(10'h020, 16'h2020);
    preload(10'h030, 16'h1111);
    preload(10'h041, 16'h4141);
    step();
    checks++; if (enb !== 1'b0) begin failures++; $display("FAIL reset_enb got=%0h want=0", enb); end
    checks++; if (ena !== 1'b0) begin failures++; $display("FAIL reset_ena got=%0h want=0", ena); end
    checks++; if (wea !== 1'b0) begin failures++; $display("FAIL reset_wea got=%0h want=0", wea); end
    checks++; if (rd_ack !== 2'b00) begin failures++; $display("FAIL reset_rd_ack got=%0h want=0", rd_ack); end
    checks++; if (wr_ack !== 1'b0) begin failures++; $display("FAIL reset_wr_ack got=%0h want=0", wr_ack); end
    checks++; if (addra !== 10'h000 || addrb !== 10'h000) begin failures++; $display("FAIL reset_addr got=%0h/%0h want=0/0", addra, addrb); end
    checks++; if (dia !== 16'h0000 || rd_data !== 16'h0000) begin failures++; $display("FAIL reset_data got=%0h/%0h want=0/0", dia, rd_data); end
    rst = 1'b0;
  endtask

  task automatic test_single_fetch();
    rd_req = 2'b01; rd_addr0 = 10'h005;
    step();
    checks++; if (enb !== 1'b1 || addrb !== 10'h005) begin failures++; $display("FAIL single_issue got enb=%0h addrb=%0h want 1/5", enb, addrb); end
    checks++; if (rd_ack !== 2'b00) begin failures++; $display("FAIL single_early_ack got=%0h want=0", rd_ack); end
    step();
    checks++; if (enb !== 1'b0) begin failures++; $display("FAIL single_enb_clear got=%0h want=0", enb); end
    step();
    checks++; if (rd_ack !== 2'b01 || rd_data !== 16'h0C01) begin failures++; $display("FAIL single_ack got ack=%0h data=%0h want 1/0c01", rd_ack, rd_data); end
    rd_req = 2'b00;
    step();
    checks++; if (rd_ack !== 2'b00) begin failures++; $display("FAIL single_ack_clear got=%0h want=0", rd_ack); end
  endtask

  task automatic test_contention();
    logic [1:0]  exp_ack;
    logic [15:0] exp_data;
    do_reset();
    rd_req = 2'b11; rd_addr0 = 10'h010; rd_addr1 = 10'h020;
    for (int k = 1; k <= 16; k++) begin
      step();
      exp_ack = 2'b00;
      if (k % 4 == 3) exp_ack = ((k / 4) % 2 == 0) ? 2'b01 : 2'b10;
      exp_data = (exp_ack == 2'b01) ? 16'h1010 : 16'h2020;
      checks++; if (rd_ack !== exp_ack) begin failures++; $display("FAIL contention_ack cyc=%0d got=%0h want=%0h", k, rd_ack, exp_ack); end
      if (exp_ack != 2'b00) begin
        checks++; if (rd_data !== exp_data) begin failures++; $display("FAIL contention_data cyc=%0d got=%0h want=%0h", k, rd_data, exp_data); end
      end
      if (k == 15) rd_req = 2'b00;
    end
  endtask

  task automatic test_raw();
    wr_req = 1'b1; wr_addr = 10'h030; wr_data = 16'hBEEF;
    rd_req = 2'b10; rd_addr1 = 10'h030;
    step();
    checks++; if (ena !== 1'b1 || wea !== 1'b1 || addra !== 10'h030 || dia !== 16'hBEEF) begin failures++; $display("FAIL raw_write_issue got ena=%0h wea=%0h addra=%0h dia=%0h want 1/1/30/beef", ena, wea, addra, dia); end
    checks++; if (enb !== 1'b0) begin failures++; $display("FAIL raw_defer1 got enb=%0h want=0", enb); end
    step();
    checks++; if (wr_ack !== 1'b1 || ena !== 1'b0) begin failures++; $display("FAIL raw_wr_ack got ack=%0h ena=%0h want 1/0", wr_ack, ena); end
    checks++; if (enb !== 1'b0) begin failures++; $display("FAIL raw_defer2 got enb=%0h want=0", enb); end
    wr_req = 1'b0;
    step();
    checks++; if (enb !== 1'b1 || addrb !== 10'h030 || wr_ack !== 1'b0) begin failures++; $display("FAIL raw_read_issue got enb=%0h addrb=%0h wr_ack=%0h want 1/30/0", enb, addrb, wr_ack); end
    step();
    checks++; if (rd_ack !== 2'b00) begin failures++; $display("FAIL raw_early_ack got=%0h want=0", rd_ack); end
    step();
    checks++; if (rd_ack !== 2'b10 || rd_data !== 16'hBEEF) begin failures++; $display("FAIL raw_read_ack got ack=%0h data=%0h want 2/beef", rd_ack, rd_data); end
    rd_req = 2'b00;
    step();
  endtask

  task automatic test_concurrent();
    wr_req = 1'b1; wr_addr = 10'h040; wr_data = 16'hA5A5;
    rd_req = 2'b01; rd_addr0 = 10'h041;
    step();
    checks++; if (ena !== 1'b1 || enb !== 1'b1 || addrb !== 10'h041) begin failures++; $display("FAIL conc_issue got ena=%0h enb=%0h addrb=%0h want 1/1/41", ena, enb, addrb); end
    step();
    checks++; if (wr_ack !== 1'b1 || rd_ack !== 2'b00) begin failures++; $display("FAIL conc_wr_ack got wr_ack=%0h rd_ack=%0h want 1/0", wr_ack, rd_ack); end
    wr_req = 1'b0;
    step();
    checks++; if (rd_ack !== 2'b01 || rd_data !== 16'h4141 || wr_ack !== 1'b0) begin failures++; $display("FAIL conc_rd_ack got ack=%0h data=%0h wr_ack=%0h want 1/4141/0", rd_ack, rd_data, wr_ack); end
    checks++; if (mem[10'h040] !== 16'hA5A5) begin failures++; $display("FAIL conc_ram got=%0h want=a5a5", mem[10'h040]); end
    rd_req = 2'b00;
    step();
  endtask

  task automatic test_dropped();
    rd_req = 2'b01; rd_addr0 = 10'h005;
    step();
    checks++; if (enb !== 1'b1 || addrb !== 10'h005) begin failures++; $display("FAIL drop_issue got enb=%0h addrb=%0h want 1/5", enb, addrb); end
    rd_req = 2'b00;
    step();
    step();
    checks++; if (rd_ack !== 2'b01 || rd_data !== 16'h0C01) begin failures++; $display("FAIL drop_ack got ack=%0h data=%0h want 1/0c01", rd_ack, rd_data); end
    step();
    checks++; if (rd_ack !== 2'b00) begin failures++; $display("FAIL drop_ack_clear got=%0h want=0", rd_ack); end
    rd_req = 2'b10; rd_addr1 = 10'h020;
    step();
    checks++; if (enb !== 1'b1 || addrb !== 10'h020) begin failures++; $display("FAIL drop_back_idle got enb=%0h addrb=%0h want 1/20", enb, addrb); end
    rd_req = 2'b00;
    step();
    step();
    checks++; if (rd_ack !== 2'b10 || rd_data !== 16'h2020) begin failures++; $display("FAIL drop_next_ack got ack=%0h data=%0h want 2/2020", rd_ack, rd_data); end
    step();
  endtask

  task automatic test_reset_mid_read();
    rd_req = 2'b01; rd_addr0 = 10'h005;
    step();
    step();
    checks++; if (enb !== 1'b0 || rd_ack !== 2'b00) begin failures++; $display("FAIL midrst_wait got enb=%0h ack=%0h want 0/0", enb, rd_ack); end
    rst = 1'b1; rd_req = 2'b00;
    step();
    checks++; if (rd_ack !== 2'b00) begin failures++; $display("FAIL midrst_no_ack got=%0h want=0", rd_ack); end
    checks++; if (rd_data !== 16'h0000 || addrb !== 10'h000 || addra !== 10'h000 || dia !== 16'h0000) begin failures++; $display("FAIL midrst_zero got rd_data=%0h addrb=%0h addra=%0h dia=%0h want 0", rd_data, addrb, addra, dia); end
    checks++; if (enb !== 1'b0 || ena !== 1'b0 || wea !== 1'b0 || wr_ack !== 1'b0) begin failures++; $display("FAIL midrst_ctl got enb=%0h ena=%0h wea=%0h wr_ack=%0h want 0", enb, ena, wea, wr_ack); end
    rst = 1'b0;
    rd_req = 2'b11; rd_addr0 = 10'h010; rd_addr1 = 10'h020;
    step();
    checks++; if (enb !== 1'b1 || addrb !== 10'h010) begin failures++; $display("FAIL midrst_tie got enb=%0h addrb=%0h want 1/10", enb, addrb); end
    step();
    step();
    checks++; if (rd_ack !== 2'b01 || rd_data !== 16'h1010) begin failures++; $display("FAIL midrst_ack got ack=%0h data=%0h want 1/1010", rd_ack, rd_data); end
    rd_req = 2'b00;
    step();
    step();
  endtask

  initial begin
    test_reset();
    test_single_fetch();
    test_contention();
    test_raw();
    test_concurrent();
    test_dropped();
    test_reset_mid_read();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
